arct_vec_iter: RTL and testbench
================================

ARCT_VEC_ITER -- requirements
Module: arct_vec_iter

Interface
REQ-001 Parameter N_ITER, default 6, number of CORDIC micro-rotations (fixed to 6; atan table holds 6 entries).
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 in_valid  input  1  source presents a vector.
REQ-005 in_ready  output  1  block can accept a vector.
REQ-006 x_in  input  16  signed two's-complement X.
REQ-007 y_in  input  16  signed two's-complement Y.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  sink accepts result.
REQ-010 mag_out  output  17  unsigned magnitude, scaled by CORDIC gain K=1.6465.
REQ-011 angle_out  output  17  signed angle, degrees, Q9.8 (range +/-256 deg).

Function
REQ-012 Vectoring-mode CORDIC: drives y toward 0, returns atan2(y_in,x_in) and K*sqrt(x^2+y^2); inverse of the rotation-mode sin/cos pipeline.
REQ-013 FSM states IDLE, ITER, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 IDLE: on in_valid&in_ready edge capture inputs into 18-bit signed x,y registers, load 17-bit z, clear iteration counter i, go to ITER.
REQ-015 Capture pre-rotation: x_in>=0 -> x=x_in, y=y_in, z=0; x_in<0 & y_in>=0 -> x=y_in, y=-x_in, z=+90 (0x05A00); x_in<0 & y_in<0 -> x=-y_in, y=x_in, z=-90 (0x1A600).
REQ-016 ITER, one micro-rotation per cycle, i=0..5: y>=0 -> x+=y>>>i, y-=x>>>i, z+=atan[i]; y<0 -> x-=y>>>i, y+=x>>>i, z-=atan[i]; shifts arithmetic, both updates use pre-cycle x,y.
REQ-017 atan table (Q8.8 degrees, sign-extended to 17 bits): 0x2D00, 0x1A90, 0x0E09, 0x0720, 0x0393, 0x01CA.
REQ-018 After i=5 cycle go to DONE; out_valid SHALL rise on the edge completing iteration 5 (acceptance edge + 6 cycles).
REQ-019 DONE: mag_out = x[16:0], angle_out = z; out_valid=1; outputs SHALL hold stable until out_valid&out_ready edge, then return to IDLE with out_valid=0.
REQ-020 Zero vector (x_in=0 and y_in=0) SHALL produce mag_out=0, angle_out=0 with identical latency.
REQ-021 x_in or y_in = -32768 SHALL negate without overflow (18-bit internal width).
REQ-022 Inputs are sampled only at acceptance; changes to x_in/y_in/in_valid during ITER/DONE SHALL have no effect.
REQ-023 Throughput: one vector per 8 cycles minimum (accept, 6 iterations, output handshake); no input accepted in the same cycle as output handshake.

Reset
REQ-024 rst=1 SHALL force state IDLE, counter 0, x/y/z 0, out_valid 0, mag_out 0, angle_out 0; in_ready=1 in the cycle after rst deasserts.
REQ-025 rst asserted mid-ITER or in DONE SHALL abandon the operation; no out_valid pulse follows.

Structure
REQ-026 Shared package SHALL hold the atan table, the +/-90 deg constants, N_ITER, and the FSM state enum; the rotation-mode pipeline SHALL reuse the same table.
REQ-027 One sub-module arct_vec_stage: combinational single micro-rotation (x,y,z,i,atan_i -> x',y',z'); the top holds FSM, counter and registers.

Verification
REQ-028 x=4096, y=4096 -> angle_out 0x02D00 +/-0x0200, mag_out 9537 +/-1%, out_valid 6 cycles after acceptance.
REQ-029 x=-4096, y=4096 -> angle_out 0x08700 (135 deg) +/-0x0200; x=-4096, y=-4096 -> 0x17900 (-135 deg) +/-0x0200; mag_out 9537 +/-1%.
REQ-030 x=0, y=0 -> mag_out 0, angle_out 0; x=-32768, y=-32768 -> mag_out 76300 +/-1%, angle -135 deg +/-2 deg.
REQ-031 Hold out_ready=0 for 5 cycles in DONE -> mag_out/angle_out/out_valid stable, in_ready=0, changing x_in ignored; out_ready=1 -> IDLE next cycle.
REQ-032 Assert rst at iteration 3 -> next cycle out_valid=0, outputs 0, in_ready=1; new vector x=8192,y=0 then yields angle 0 +/-2 deg, mag 13488 +/-1%.

Source files
------------

// File: rtl/arct_vec_iter_pkg.sv
// ============================================================================
//  Module   : arct_vec_iter_pkg
//  Purpose  : Shared CORDIC constants, atan table and FSM state encoding
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arct_vec_iter_pkg;

    localparam int c_n_iter = 6;
    localparam int c_xy_w   = 18;
    localparam int c_z_w    = 17;

    // Quadrant pre-rotation offsets, Q9.8 degrees
    localparam logic [c_z_w-1:0] c_z_pos90 = 17'h05A00;
    localparam logic [c_z_w-1:0] c_z_neg90 = 17'h1A600;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } vec_state_t;

    // atan(2^-i) in Q8.8 degrees, shared with the rotation-mode pipeline
    function automatic logic [c_z_w-1:0] atan_lut(input logic [2:0] idx);
        logic [c_z_w-1:0] v;
        case (idx)
            3'd0:    v = 17'h02D00;
            3'd1:    v = 17'h01A90;
            3'd2:    v = 17'h00E09;
            3'd3:    v = 17'h00720;
            3'd4:    v = 17'h00393;
            3'd5:    v = 17'h001CA;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arct_vec_stage.sv
// ============================================================================
//  Module   : arct_vec_stage
//  Purpose  : One combinational vectoring-mode CORDIC micro-rotation
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arct_vec_stage
    import arct_vec_iter_pkg::*;
(
    input  logic signed [c_xy_w-1:0] i_x,
    input  logic signed [c_xy_w-1:0] i_y,
    input  logic        [c_z_w-1:0]  i_z,
    input  logic        [2:0]        i_shift,
    input  logic        [c_z_w-1:0]  i_atan,
    output logic signed [c_xy_w-1:0] o_x,
    output logic signed [c_xy_w-1:0] o_y,
    output logic        [c_z_w-1:0]  o_z
);

    logic signed [c_xy_w-1:0] w_xs;
    logic signed [c_xy_w-1:0] w_ys;

    assign w_xs = i_x >>> i_shift;
    assign w_ys = i_y >>> i_shift;

    // Rotate toward y = 0, accumulating the applied angle in z
    always_comb begin
        if (!i_y[c_xy_w-1]) begin
            o_x = i_x + w_ys;
            o_y = i_y - w_xs;
            o_z = i_z + i_atan;
        end else begin
            o_x = i_x - w_ys;
            o_y = i_y + w_xs;
            o_z = i_z - i_atan;
        end
    end

endmodule

`default_nettype wire

// File: rtl/arct_vec_iter.sv
// ============================================================================
//  Module   : arct_vec_iter
//  Purpose  : Iterative vectoring CORDIC returning magnitude and atan2 angle
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arct_vec_iter
    import arct_vec_iter_pkg::*;
#(
    parameter int N_ITER = c_n_iter
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [16:0]        mag_out,
    output logic [16:0]        angle_out
);

    vec_state_t               r_state;
    logic        [2:0]        r_i;
    logic signed [c_xy_w-1:0] r_x;
    logic signed [c_xy_w-1:0] r_y;
    logic        [c_z_w-1:0]  r_z;
    logic                     r_zero;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic        [16:0]       r_mag;
    logic        [16:0]       r_ang;

    logic signed [c_xy_w-1:0] w_xe;
    logic signed [c_xy_w-1:0] w_ye;
    logic signed [c_xy_w-1:0] w_cap_x;
    logic signed [c_xy_w-1:0] w_cap_y;
    logic        [c_z_w-1:0]  w_cap_z;
    logic signed [c_xy_w-1:0] w_nx;
    logic signed [c_xy_w-1:0] w_ny;
    logic        [c_z_w-1:0]  w_nz;
    logic                     w_last;

    assign w_xe   = {{(c_xy_w-16){x_in[15]}}, x_in};
    assign w_ye   = {{(c_xy_w-16){y_in[15]}}, y_in};
    assign w_last = (r_i == 3'(N_ITER - 1));

    // Fold left half-plane inputs into the right half-plane by +/-90 deg
    always_comb begin
        w_cap_x = w_xe;
        w_cap_y = w_ye;
        w_cap_z = '0;
        if (x_in[15]) begin
            if (!y_in[15]) begin
                w_cap_x = w_ye;
                w_cap_y = -w_xe;
                w_cap_z = c_z_pos90;
            end else begin
                w_cap_x = -w_ye;
                w_cap_y = w_xe;
                w_cap_z = c_z_neg90;
            end
        end
    end

    arct_vec_stage u_stage (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_shift (r_i),
        .i_atan  (atan_lut(r_i)),
        .o_x     (w_nx),
        .o_y     (w_ny),
        .o_z     (w_nz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_i         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mag       <= '0;
            r_ang       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_x        <= w_cap_x;
                        r_y        <= w_cap_y;
                        r_z        <= w_cap_z;
                        r_i        <= '0;
                        r_zero     <= (x_in == 16'sd0) && (y_in == 16'sd0);
                        r_in_ready <= 1'b0;
                        r_state    <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    r_x <= w_nx;
                    r_y <= w_ny;
                    r_z <= w_nz;
                    r_i <= r_i + 3'd1;
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_mag       <= w_nx[16:0];
                        // A zero vector has no defined angle; the iterations would sum every atan entry
                        r_ang       <= r_zero ? '0 : w_nz;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign mag_out   = r_mag;
    assign angle_out = r_ang;

endmodule

`default_nettype wire

// File: tb/tb_arct_vec_iter.sv
// ============================================================================
//  Module   : tb_arct_vec_iter
//  Purpose  : Scoreboard bench for arct_vec_iter against real-valued atan2/hypot
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arct_vec_iter;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               out_valid;
    logic               out_ready;
    logic [16:0]        mag_out;
    logic [16:0]        angle_out;

    int n_cmp = 0;
    int n_err = 0;
    int qx[$];
    int qy[$];

    arct_vec_iter #(.N_ITER(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real exp_mag(input int x, input int y);
        return 1.6465 * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    endfunction

    function automatic real exp_ang(input int x, input int y);
        return $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979 * 256.0;
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Drive one vector and return just after the accepting edge
    task automatic send_vec(input int x, input int y);
        int c;
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 16'(x);
        y_in     = 16'(y);
        c = 0;
        while (!in_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_err++;
            $display("FAIL send_accept: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        qx.push_back(x);
        qy.push_back(y);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || mag_out !== 17'd0 || angle_out !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs: ov=%0b mag=%0d ang=%0h required 0/0/0", out_valid, mag_out, angle_out);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_diagonals();
        int vx[3] = '{4096, -4096, -4096};
        int vy[3] = '{4096, 4096, -4096};
        int lat, ex, ey, a;
        real em, ea;
        for (int k = 0; k < 3; k++) begin
            send_vec(vx[k], vy[k]);
            wait_out(lat);
            n_cmp++;
            if (lat !== 6) begin
                n_err++;
                $display("FAIL diag_latency[%0d]: got %0d required 6", k, lat);
            end
            ex = qx.pop_front();
            ey = qy.pop_front();
            em = exp_mag(ex, ey);
            ea = exp_ang(ex, ey);
            a  = int'($signed(angle_out));
            n_cmp++;
            if (rabs(real'(mag_out) - em) > 0.01 * em) begin
                n_err++;
                $display("FAIL diag_mag[%0d]: got %0d required %0.1f +/-1%%", k, mag_out, em);
            end
            n_cmp++;
            if (rabs(real'(a) - ea) > 512.0) begin
                n_err++;
                $display("FAIL diag_angle[%0d]: got %0d required %0.1f +/-512", k, a, ea);
            end
            handshake();
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL diag_release[%0d]: ov=%0b ir=%0b required 0/1", k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_edges();
        int vx[5] = '{0, -32768, 5, -32768, 12345};
        int vy[5] = '{0, -32768, -32768, 0, 0};
        int lat, ex, ey, a;
        real em, ea;
        for (int k = 0; k < 5; k++) begin
            send_vec(vx[k], vy[k]);
            wait_out(lat);
            n_cmp++;
            if (lat !== 6) begin
                n_err++;
                $display("FAIL edge_latency[%0d]: got %0d required 6", k, lat);
            end
            ex = qx.pop_front();
            ey = qy.pop_front();
            a  = int'($signed(angle_out));
            if (ex == 0 && ey == 0) begin
                n_cmp++;
                if (mag_out !== 17'd0 || angle_out !== 17'd0) begin
                    n_err++;
                    $display("FAIL edge_zero: mag=%0d ang=%0h required 0/0", mag_out, angle_out);
                end
            end else begin
                em = exp_mag(ex, ey);
                ea = exp_ang(ex, ey);
                n_cmp++;
                if (rabs(real'(mag_out) - em) > 0.01 * em) begin
                    n_err++;
                    $display("FAIL edge_mag[%0d]: got %0d required %0.1f +/-1%%", k, mag_out, em);
                end
                n_cmp++;
                if (rabs(real'(a) - ea) > 512.0) begin
                    n_err++;
                    $display("FAIL edge_angle[%0d]: got %0d required %0.1f +/-512", k, a, ea);
                end
            end
            handshake();
        end
    endtask

    task automatic test_hold();
        int lat, ex, ey, a;
        logic [16:0] m0, a0;
        real em, ea;
        send_vec(3000, -7000);
        wait_out(lat);
        m0 = mag_out;
        a0 = angle_out;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            x_in     = 16'($urandom_range(0, 65535));
            y_in     = 16'($urandom_range(0, 65535));
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || mag_out !== m0 || angle_out !== a0) begin
                n_err++;
                $display("FAIL hold_stable[%0d]: ov=%0b ir=%0b mag=%0d ang=%0h required 1/0/%0d/%0h",
                         c, out_valid, in_ready, mag_out, angle_out, m0, a0);
            end
        end
        in_valid = 1'b0;
        ex = qx.pop_front();
        ey = qy.pop_front();
        em = exp_mag(ex, ey);
        ea = exp_ang(ex, ey);
        a  = int'($signed(angle_out));
        n_cmp++;
        if (rabs(real'(mag_out) - em) > 0.01 * em || rabs(real'(a) - ea) > 512.0) begin
            n_err++;
            $display("FAIL hold_value: mag=%0d ang=%0d required %0.1f/%0.1f", mag_out, a, em, ea);
        end
        handshake();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release: ov=%0b ir=%0b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat, ex, ey, a, seen;
        real em, ea;
        send_vec(8192, 8192);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        qx.delete();
        qy.delete();
        n_cmp++;
        if (out_valid !== 1'b0 || mag_out !== 17'd0 || angle_out !== 17'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_state: ov=%0b mag=%0d ang=%0h ir=%0b required 0/0/0/1",
                     out_valid, mag_out, angle_out, in_ready);
        end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL rstmid_no_pulse: out_valid cycles=%0d required 0", seen);
        end
        send_vec(8192, 0);
        wait_out(lat);
        ex = qx.pop_front();
        ey = qy.pop_front();
        em = exp_mag(ex, ey);
        ea = exp_ang(ex, ey);
        a  = int'($signed(angle_out));
        n_cmp++;
        if (lat !== 6 || rabs(real'(mag_out) - em) > 0.01 * em || rabs(real'(a) - ea) > 512.0) begin
            n_err++;
            $display("FAIL rstmid_after: lat=%0d mag=%0d ang=%0d required 6/%0.1f/%0.1f", lat, mag_out, a, em, ea);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int vx[4] = '{12000, -20000, 100, -32768};
        int vy[4] = '{-3000, 7000, -30000, 5};
        int lat, ex, ey, a, c;
        real em, ea;
        time t_acc, t_prev;
        t_prev    = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x_in     = 16'(vx[k]);
            y_in     = 16'(vy[k]);
            c = 0;
            while (!in_ready && c < 20) begin
                @(negedge clk);
                c++;
            end
            @(posedge clk);
            t_acc = $time;
            qx.push_back(vx[k]);
            qy.push_back(vy[k]);
            #1;
            x_in = ~x_in;
            y_in = ~y_in;
            if (k > 0) begin
                n_cmp++;
                if (t_acc - t_prev !== 80) begin
                    n_err++;
                    $display("FAIL b2b_interval[%0d]: got %0t required 80", k, t_acc - t_prev);
                end
            end
            t_prev = t_acc;
            wait_out(lat);
            ex = qx.pop_front();
            ey = qy.pop_front();
            em = exp_mag(ex, ey);
            ea = exp_ang(ex, ey);
            a  = int'($signed(angle_out));
            n_cmp++;
            if (lat !== 6 || rabs(real'(mag_out) - em) > 0.01 * em || rabs(real'(a) - ea) > 512.0) begin
                n_err++;
                $display("FAIL b2b_result[%0d]: lat=%0d mag=%0d ang=%0d required 6/%0.1f/%0.1f",
                         k, lat, mag_out, a, em, ea);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        test_reset();
        test_diagonals();
        test_edges();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
